sap_core: RTL

- Parametrised successor of the SAP-1 computer: one self-contained CPU core. Contains PC, MAR, IR, accumulator A, register B, output register, Z/C flags, internal program/data RAM and a T-state controller.
- Adds STA, JMP, JZ and JC to the original LDA/ADD/SUB/OUT/HLT.
- Used as the top of each sap board build. The load-mode programming port replaces the switch-driven memory load.

---
 rtl/sap_pkg.sv | 52 +++++
 rtl/sap_ram.sv | 30 +++
 rtl/sap_core.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// sap_pkg -- shared definitions for the sap_core CPU.
//   * 4-bit opcode constants (opcode always sits in the top nibble of IR)
//   * one-hot T-state encoding, with all-zero meaning HALT
//   * control-word struct produced by the controller each T-state
//   * last_t(): final active T-state of an opcode, used when the core is
//     built with SAP_VARIABLE_CYCLE_EN defined
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [5:0] {
    T_HALT = 6'b000000,
    T1     = 6'b000001,
    T2     = 6'b000010,
    T3     = 6'b000100,
    T4     = 6'b001000,
    T5     = 6'b010000,
    T6     = 6'b100000
  } tstate_e;

  typedef struct packed {
    logic mar_from_pc;
    logic pc_inc;
    logic ir_ld;
    logic mar_from_op;
    logic a_from_ram;
    logic b_from_ram;
    logic alu_ld;
    logic ram_we;
    logic pc_jmp;
    logic out_ld;
  } ctrl_t;

  function automatic tstate_e last_t(input logic [3:0] op);
    tstate_e last;
    case (op)
      OP_ADD, OP_SUB: last = T6;
      OP_LDA, OP_STA: last = T5;
      default:        last = T4;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/sap_ram.sv
// sap_ram -- 2**AW x DW program/data memory.
//   clk    : write clock
//   we     : write strobe (already muxed between load port and STA)
//   waddr  : write address
//   wdata  : write data
//   raddr  : combinational read address (driven by MAR)
//   rdata  : combinational read data
module sap_ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];

  // NOTE: memory arrays get no reset so they map onto RAM cells; contents
  // survive n_clr, which is what lets a program be re-run after a clear.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sap_core.sv
// sap_core -- SAP-1 style CPU core with STA/JMP/JZ/JC extensions.
//   clk       : rising-edge clock
//   n_clr     : asynchronous active-low clear
//   prog      : 1 = load mode (core held at T1, RAM writable), 0 = execute
//   prog_we   : RAM write strobe, honoured only while prog = 1
//   prog_addr : RAM write address in load mode
//   prog_data : RAM write data in load mode
//   out       : output (display) register
//   halted    : 1 while in HALT
//   zf, cf    : zero flag, carry / no-borrow flag
//   t         : one-hot T-state T1..T6, all zero in HALT
// Build option: SAP_VARIABLE_CYCLE_EN -- when defined, each instruction
// returns to T1 right after its last active T-state instead of after T6.
// DW must be at least AW+4 so opcode and operand fields do not overlap.
module sap_core import sap_pkg::*; #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          n_clr,
  input  logic          prog,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] out,
  output logic          halted,
  output logic          zf,
  output logic          cf,
  output logic [5:0]    t
);

  tstate_e       t_q, t_d;
  logic [AW-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DW-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic          zf_q, zf_d, cf_q, cf_d;

  ctrl_t         ctrl;
  logic [3:0]    opcode;
  logic [AW-1:0] operand;
  logic [DW-1:0] ram_rdata;
  logic [DW:0]   alu_sum, alu_diff;
  logic [DW-1:0] alu_res;
  logic          alu_cf;

  assign opcode  = ir_q[DW-1 -: 4];
  assign operand = ir_q[AW-1:0];

  sap_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (prog ? prog_we : ctrl.ram_we),
    .waddr (prog ? prog_addr : mar_q),
    .wdata (prog ? prog_data : a_q),
    .raddr (mar_q),
    .rdata (ram_rdata)
  );

  // State register for the whole core.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      t_q   <= T1;
      pc_q  <= '0;
      mar_q <= '0;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      zf_q  <= 1'b0;
      cf_q  <= 1'b0;
    end else begin
      t_q   <= t_d;
      pc_q  <= pc_d;
      mar_q <= mar_d;
      ir_q  <= ir_d;
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      zf_q  <= zf_d;
      cf_q  <= cf_d;
    end
  end

  // Next T-state. Load mode wins over everything, including HALT.
  always_comb begin
    // NOTE: a default assignment up front means no path leaves t_d
    // unassigned, so no latch is inferred.
    t_d = t_q;
    if (prog) begin
      t_d = T1;
    end else if (t_q == T4 && opcode == OP_HLT) begin
      t_d = T_HALT;
`ifdef SAP_VARIABLE_CYCLE_EN
    end else if (t_q == last_t(opcode)) begin
      t_d = T1;
`endif
    end else begin
      unique case (t_q)
        T1:      t_d = T2;
        T2:      t_d = T3;
        T3:      t_d = T4;
        T4:      t_d = T5;
        T5:      t_d = T6;
        T6:      t_d = T1;
        T_HALT:  t_d = T_HALT;
        default: t_d = T1;
      endcase
    end
  end

  // Control word for the current T-state. Fetch is opcode-independent;
  // IR is only meaningful from T4 on.
  always_comb begin
    ctrl = '0;
    unique case (t_q)
      T1: ctrl.mar_from_pc = 1'b1;
      T2: ctrl.pc_inc      = 1'b1;
      T3: ctrl.ir_ld       = 1'b1;
      T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl.mar_from_op = 1'b1;
          OP_JMP:  ctrl.pc_jmp = 1'b1;
          OP_JZ:   ctrl.pc_jmp = zf_q;
          OP_JC:   ctrl.pc_jmp = cf_q;
          OP_OUT:  ctrl.out_ld = 1'b1;
          default: ;
        endcase
      end
      T5: begin
        case (opcode)
          OP_LDA:         ctrl.a_from_ram = 1'b1;
          OP_ADD, OP_SUB: ctrl.b_from_ram = 1'b1;
          OP_STA:         ctrl.ram_we     = 1'b1;
          default: ;
        endcase
      end
      T6: begin
        if (opcode == OP_ADD || opcode == OP_SUB) ctrl.alu_ld = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU: extra top bit captures carry (ADD) or borrow (SUB).
  always_comb begin
    alu_sum  = {1'b0, a_q} + {1'b0, b_q};
    alu_diff = {1'b0, a_q} - {1'b0, b_q};
    if (opcode == OP_SUB) begin
      alu_res = alu_diff[DW-1:0];
      alu_cf  = ~alu_diff[DW];
    end else begin
      alu_res = alu_sum[DW-1:0];
      alu_cf  = alu_sum[DW];
    end
  end

  // Datapath next-state. Load mode clears the fetch path but keeps A, B,
  // out and the flags, and suppresses any half-done instruction.
  always_comb begin
    pc_d  = pc_q;
    mar_d = mar_q;
    ir_d  = ir_q;
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    zf_d  = zf_q;
    cf_d  = cf_q;
    if (prog) begin
      pc_d  = '0;
      mar_d = '0;
      ir_d  = '0;
    end else begin
      if (ctrl.mar_from_pc) mar_d = pc_q;
      if (ctrl.pc_inc)      pc_d  = pc_q + AW'(1);
      if (ctrl.ir_ld)       ir_d  = ram_rdata;
      if (ctrl.mar_from_op) mar_d = operand;
      if (ctrl.pc_jmp)      pc_d  = operand;
      if (ctrl.a_from_ram)  a_d   = ram_rdata;
      if (ctrl.b_from_ram)  b_d   = ram_rdata;
      if (ctrl.out_ld)      out_d = a_q;
      if (ctrl.alu_ld) begin
        a_d  = alu_res;
        zf_d = (alu_res == '0);
        cf_d = alu_cf;
      end
    end
  end

  assign out    = out_q;
  assign halted = (t_q == T_HALT);
  assign zf     = zf_q;
  assign cf     = cf_q;
  assign t      = t_q;

endmodule
